grant_xfer_ctrl: RTL
====================

# grant_xfer_ctrl

Transfer controller that sits directly downstream of the two-requester grant FSM and consumes its one-hot `gnt_0`/`gnt_1` outputs. It steers the owning requester's beats onto a single shared sink port through one registered output stage. It bounds each tenure to a burst limit and pulses `done_n` so the requester drops `req_n` and releases the grant. It also flags grant-protocol faults: a simultaneous grant, or a grant lost mid-burst.

## Interface
- `DATA_W`, default 8: beat data width.
- `BURST_MAX`, default 4: maximum beats per tenure. Must be ≥2.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `gnt_0`, `gnt_1`, input, 1 each: registered grants from the arbiter.
- `src0_valid`, `src1_valid`, input, 1 each: requester beat valid.
- `src0_data`, `src1_data`, input, DATA_W each: requester beat data.
- `src0_last`, `src1_last`, input, 1 each: marks the final beat of the requester's burst.
- `src0_ready`, `src1_ready`, output, 1 each: beat accepted this cycle. Combinational.
- `snk_valid`, output, 1: registered beat valid.
- `snk_data`, output, DATA_W: registered beat data.
- `snk_src`, output, 1: owner of the current sink beat (0 or 1).
- `snk_last`, output, 1: marks the last beat of the tenure.
- `snk_ready`, input, 1: sink accepts the beat.
- `done_0`, `done_1`, output, 1 each: one-cycle pulse at normal tenure end.
- `abort_0`, `abort_1`, output, 1 each: one-cycle pulse when the grant drops mid-burst.
- `err_both`, output, 1: sticky flag. Set when both grants are high. Cleared only by `rst`.

## Operation
- States: IDLE, XFER0, XFER1, REL0, REL1. Reset state is IDLE.
- Beat counter `cnt`:
  - Width `$clog2(BURST_MAX)`.
  - Cleared on every entry to an XFER state.
  - Incremented on each accepted beat.
- `srcN_ready` = (state==XFERn) & gnt_n & !gnt_other & (!snk_valid | snk_ready). The non-owner's ready is always 0.
- A beat is accepted when `srcN_valid & srcN_ready`.
- Terminal beat: an accepted beat with `srcN_last`, or with `cnt==BURST_MAX-1`.
- Transitions, with priority top to bottom:
  - Any state, `gnt_0 & gnt_1`: set `err_both`, go to IDLE, no acceptance that cycle.
  - IDLE, `gnt_0` only: go to XFER0. `gnt_1` only: go to XFER1. Neither: stay.
  - XFERn, terminal beat accepted: go to RELn and pulse `done_n`.
  - XFERn, `gnt_n` low: go to IDLE and pulse `abort_n`. Any beat already in the output register still drains.
  - RELn, `gnt_n` low: go to IDLE. While `gnt_n` stays high, stay in RELn and accept nothing.
- Output register:
  - On acceptance: `snk_valid`←1, `snk_data`←src data, `snk_src`←n, `snk_last`←terminal.
  - Else, if `snk_ready`: `snk_valid`←0.
  - `snk_data`, `snk_src` and `snk_last` hold their value while `snk_valid`=1 and `snk_ready`=0.
  - The register drains in every state, including IDLE and REL.
- Reset values: `snk_valid`, `snk_data`, `snk_src`, `snk_last`, all `done_*`, all `abort_*` and `err_both` are 0. `srcN_ready` is 0 because the state is IDLE.
- Reset asserted mid-burst: state returns to IDLE, the output beat is discarded (`snk_valid`=0), and no done or abort pulse is issued.

## Timing
- Grant edge to first `srcN_ready`: 1 cycle. Grant seen in IDLE at edge k, XFER at k+1, ready can assert in cycle k+1.
- Source acceptance to `snk_valid`: 1 cycle.
- Full throughput with `snk_ready` held high: one beat per cycle.
- `done_n` is registered and asserts the cycle after the terminal beat is accepted, concurrently with RELn.
- The arbiter drops `gnt_n` two cycles after `req_n` falls. REL absorbs this latency, so no beat is accepted in it.
- `abort_n` asserts the cycle after `gnt_n` is sampled low in XFERn.

## Structure
- Package `grant_xfer_pkg` holds:
  - State enum `xfer_state_t` (one-hot, 5 bits).
  - The `BURST_MAX` default.
- One sub-module, `xfer_out_reg`: the DATA_W+2-bit valid/ready output register stage.
- The FSM, counter and steering mux stay in the top level.

## Test plan
- `gnt_0`=1, src0 sends 3 beats (0x11, 0x22, 0x33 with last) and `snk_ready`=1. Expect the sink to see 3 beats with `snk_src`=0 and `snk_last` on 0x33, then `done_0` one cycle later, state REL0, and `src0_ready`=0 until `gnt_0` falls.
- `gnt_1`=1, src1 streams 6 beats without last. Expect exactly 4 beats accepted, `snk_last` on beat 4, `done_1`, and beats 5–6 not accepted.
- Burst in progress with `snk_ready`=0 for 3 cycles. Expect the data to hold stable, `src0_ready`=0, and no beat lost or duplicated.
- Drop `gnt_0` after 2 beats. Expect `abort_0` for 1 cycle, IDLE, and no `done_0`; a pending beat still drains.
- Drive `gnt_0`=`gnt_1`=1 for 1 cycle. Expect `err_both`=1, held until `rst`, and no ready asserted that cycle.
- Assert `rst` mid-burst. Expect all outputs 0 the next cycle, and a new grant starts a fresh burst with `cnt`=0.

Source files
------------

// File: rtl/grant_xfer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grant_xfer_pkg : shared types for the grant transfer controller   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package grant_xfer_pkg;

  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_XFER0 = 5'b00010,
    ST_XFER1 = 5'b00100,
    ST_REL0  = 5'b01000,
    ST_REL1  = 5'b10000
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/xfer_out_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xfer_out_reg : single valid/ready register holding one sink beat  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module xfer_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_src,
  input  logic              load_last,
  input  logic              snk_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  output logic              snk_src,
  output logic              snk_last
);

  // Payload fields only change on a new load, so they hold through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      snk_valid <= 1'b0;
      snk_data  <= '0;
      snk_src   <= 1'b0;
      snk_last  <= 1'b0;
    end else if (load) begin
      snk_valid <= 1'b1;
      snk_data  <= load_data;
      snk_src   <= load_src;
      snk_last  <= load_last;
    end else if (snk_ready) begin
      snk_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/grant_xfer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grant_xfer_ctrl : steers the granted requester onto one sink port |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module grant_xfer_ctrl
  import grant_xfer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              src0_valid,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src0_data,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src0_last,
  input  logic              src1_last,
  output logic              src0_ready,
  output logic              src1_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  output logic              snk_src,
  output logic              snk_last,
  input  logic              snk_ready,
  output logic              done_0,
  output logic              done_1,
  output logic              abort_0,
  output logic              abort_1,
  output logic              err_both
);

  localparam int              CNT_W   = $clog2(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BURST_MAX - 1);

  xfer_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_both;
  logic              w_slot_free;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_term0;
  logic              w_term1;
  logic              w_load;
  logic              w_load_last;
  logic [DATA_W-1:0] w_load_data;

  assign w_both      = gnt_0 & gnt_1;
  assign w_slot_free = ~snk_valid | snk_ready;

  assign src0_ready  = (r_state == ST_XFER0) & gnt_0 & ~gnt_1 & w_slot_free;
  assign src1_ready  = (r_state == ST_XFER1) & gnt_1 & ~gnt_0 & w_slot_free;

  assign w_acc0      = src0_valid & src0_ready;
  assign w_acc1      = src1_valid & src1_ready;
  assign w_term0     = w_acc0 & (src0_last | (r_cnt == CNT_TOP));
  assign w_term1     = w_acc1 & (src1_last | (r_cnt == CNT_TOP));

  // At most one of w_acc0/w_acc1 can be high, so a simple select suffices.
  assign w_load      = w_acc0 | w_acc1;
  assign w_load_data = w_acc1 ? src1_data : src0_data;
  assign w_load_last = w_acc1 ? w_term1 : w_term0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      done_0   <= 1'b0;
      done_1   <= 1'b0;
      abort_0  <= 1'b0;
      abort_1  <= 1'b0;
      err_both <= 1'b0;
    end else begin
      done_0  <= 1'b0;
      done_1  <= 1'b0;
      abort_0 <= 1'b0;
      abort_1 <= 1'b0;
      if (w_both) begin
        err_both <= 1'b1;
        r_state  <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (gnt_0) begin
              r_state <= ST_XFER0;
              r_cnt   <= '0;
            end else if (gnt_1) begin
              r_state <= ST_XFER1;
              r_cnt   <= '0;
            end
          end
          ST_XFER0: begin
            if (w_term0) begin
              r_state <= ST_REL0;
              done_0  <= 1'b1;
            end else if (!gnt_0) begin
              r_state <= ST_IDLE;
              abort_0 <= 1'b1;
            end else if (w_acc0) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_XFER1: begin
            if (w_term1) begin
              r_state <= ST_REL1;
              done_1  <= 1'b1;
            end else if (!gnt_1) begin
              r_state <= ST_IDLE;
              abort_1 <= 1'b1;
            end else if (w_acc1) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          // REL waits out the arbiter's grant-drop latency.
          ST_REL0: if (!gnt_0) r_state <= ST_IDLE;
          ST_REL1: if (!gnt_1) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  xfer_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .load_data (w_load_data),
    .load_src  (w_acc1),
    .load_last (w_load_last),
    .snk_ready (snk_ready),
    .snk_valid (snk_valid),
    .snk_data  (snk_data),
    .snk_src   (snk_src),
    .snk_last  (snk_last)
  );

endmodule
`default_nettype wire
